vmproj_page_memory: RTL and testbench

- Paged, bx-addressed memory that sits directly downstream of the projection router.
- Accepts one router output port (data-array write port plus per-page nentries strobes) and serves a read port to the match engine.
- Each page holds the entries of one bx; the page is selected by the writeaddr/readaddr MSBs.
- Per-page entry counts are registered and exported, so the consumer knows how many entries are valid in its page.

---
 rtl/vmproj_page_memory_pkg.sv | 26 ++
 rtl/vmproj_page_memory_sdp_bram_readfirst.sv | 77 +++++++
 rtl/vmproj_page_memory.sv | 79 +++++++
 tb/tb_vmproj_page_memory.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vmproj_page_memory_pkg.sv
// Shared constants and helpers for the paged projection memory.
// Entry widths and page counts match the standard router output flavours.
package vmproj_page_memory_pkg;

    localparam int NENTRIES_WIDTH = 8;

    localparam int VMPROJ_DATA_WIDTH  = 21;
    localparam int ALLPROJ_DATA_WIDTH = 60;
    localparam int TPROJ_DATA_WIDTH   = 60;

    localparam int VMPROJ_NPAGES  = 2;
    localparam int ALLPROJ_NPAGES = 8;

    function automatic int calc_addr_width(input int npages, input int page_depth);
        return $clog2(npages * page_depth);
    endfunction

    // A page can never hold more entries than it has slots.
    function automatic logic count_overflows(input logic [NENTRIES_WIDTH-1:0] count,
                                             input int page_depth);
        int count_int;
        count_int = 32'(count);
        return (count_int > page_depth);
    endfunction

endpackage

// File: rtl/vmproj_page_memory_sdp_bram_readfirst.sv
// Simple-dual-port, read-first RAM with an optional output register.
// Only the read pipeline is reset; the array itself is left uninitialised.
module sdp_bram_readfirst
    import vmproj_page_memory_pkg::*;
#(
    parameter int DATA_WIDTH   = VMPROJ_DATA_WIDTH,
    parameter int DEPTH        = 256,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] stage1_q;
    logic [DATA_WIDTH-1:0] stage1_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reading the array before the write lands gives read-first collisions.
    always_comb begin
        stage1_d = stage1_q;
        if (rd_en) begin
            stage1_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1_q <= '0;
        end else begin
            stage1_q <= stage1_d;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_out_reg
            logic                  stage1_vld_q;
            logic [DATA_WIDTH-1:0] stage2_q;
            logic [DATA_WIDTH-1:0] stage2_d;

            always_comb begin
                stage2_d = stage2_q;
                if (stage1_vld_q) begin
                    stage2_d = stage1_q;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stage1_vld_q <= 1'b0;
                    stage2_q     <= '0;
                end else begin
                    stage1_vld_q <= rd_en;
                    stage2_q     <= stage2_d;
                end
            end

            assign rd_data = stage2_q;
        end else begin : g_no_out_reg
            assign rd_data = stage1_q;
        end
    endgenerate

endmodule

// File: rtl/vmproj_page_memory.sv
// Paged bx memory behind the projection router: data RAM plus per-page entry
// counts and sticky overflow flags exported to the match engine.
module vmproj_page_memory
    import vmproj_page_memory_pkg::*;
#(
    parameter int DATA_WIDTH   = VMPROJ_DATA_WIDTH,
    parameter int NPAGES       = VMPROJ_NPAGES,
    parameter int PAGE_DEPTH   = 128,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = calc_addr_width(NPAGES, PAGE_DEPTH)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ena,
    input  logic                             wea,
    input  logic [ADDR_WIDTH-1:0]            writeaddr,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic [NPAGES-1:0]                nentries_we,
    input  logic [NENTRIES_WIDTH*NPAGES-1:0] nentries_din,
    input  logic                             enb,
    input  logic [ADDR_WIDTH-1:0]            readaddr,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic [NENTRIES_WIDTH*NPAGES-1:0] nentries_dout,
    output logic [NPAGES-1:0]                overflow
);

    localparam int DEPTH = NPAGES * PAGE_DEPTH;

    logic [NENTRIES_WIDTH*NPAGES-1:0] nentries_q;
    logic [NENTRIES_WIDTH*NPAGES-1:0] nentries_d;
    logic [NPAGES-1:0]                overflow_q;
    logic [NPAGES-1:0]                overflow_d;

    sdp_bram_readfirst #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (ena & wea),
        .wr_addr(writeaddr),
        .wr_data(din),
        .rd_en  (enb),
        .rd_addr(readaddr),
        .rd_data(dout)
    );

    // Oversized counts are still stored so the consumer sees what the router sent.
    always_comb begin
        nentries_d = nentries_q;
        overflow_d = overflow_q;
        for (int p = 0; p < NPAGES; p++) begin
            if (nentries_we[p]) begin
                nentries_d[NENTRIES_WIDTH*p +: NENTRIES_WIDTH] =
                    nentries_din[NENTRIES_WIDTH*p +: NENTRIES_WIDTH];
                if (count_overflows(nentries_din[NENTRIES_WIDTH*p +: NENTRIES_WIDTH],
                                    PAGE_DEPTH)) begin
                    overflow_d[p] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nentries_q <= '0;
            overflow_q <= '0;
        end else begin
            nentries_q <= nentries_d;
            overflow_q <= overflow_d;
        end
    end

    assign nentries_dout = nentries_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_vmproj_page_memory.sv
// Self-checking bench for vmproj_page_memory: directed scenarios followed by
// randomized traffic, checked against an array/queue-level reference model.
module tb_vmproj_page_memory;

   localparam int DW = 21;
   localparam int NP = 2;
   localparam int PD = 128;
   localparam int AW = 8;
   localparam int NWORDS = NP * PD;

   logic            clk = 1'b0;
   logic            reset;
   logic            ena;
   logic            wea;
   logic [AW-1:0]   writeaddr;
   logic [DW-1:0]   din;
   logic [NP-1:0]   nentries_we;
   logic [8*NP-1:0] nentries_din;
   logic            enb;
   logic [AW-1:0]   readaddr;
   logic [DW-1:0]   dout1;
   logic [DW-1:0]   dout2;
   logic [8*NP-1:0] nentries_dout1;
   logic [8*NP-1:0] nentries_dout2;
   logic [NP-1:0]   overflow1;
   logic [NP-1:0]   overflow2;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] refMem [NWORDS];
   logic [DW-1:0] expDout1;
   logic [DW-1:0] expDout2;
   logic          expEnbPrev;
   int            refCount [NP];
   bit            refOverflow [NP];

   vmproj_page_memory #(
      .DATA_WIDTH(DW), .NPAGES(NP), .PAGE_DEPTH(PD), .READ_LATENCY(1)
   ) dutLat1 (
      .clk(clk), .reset(reset), .ena(ena), .wea(wea), .writeaddr(writeaddr),
      .din(din), .nentries_we(nentries_we), .nentries_din(nentries_din),
      .enb(enb), .readaddr(readaddr), .dout(dout1),
      .nentries_dout(nentries_dout1), .overflow(overflow1)
   );

   vmproj_page_memory #(
      .DATA_WIDTH(DW), .NPAGES(NP), .PAGE_DEPTH(PD), .READ_LATENCY(2)
   ) dutLat2 (
      .clk(clk), .reset(reset), .ena(ena), .wea(wea), .writeaddr(writeaddr),
      .din(din), .nentries_we(nentries_we), .nentries_din(nentries_din),
      .enb(enb), .readaddr(readaddr), .dout(dout2),
      .nentries_dout(nentries_dout2), .overflow(overflow2)
   );

   // Free-running clock, posedges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [8*NP-1:0] expectedCounts();
      logic [8*NP-1:0] packed_counts;
      for (int p = 0; p < NP; p++) begin
         packed_counts[8*p +: 8] = 8'(refCount[p]);
      end
      return packed_counts;
   endfunction

   function automatic logic [NP-1:0] expectedOverflow();
      logic [NP-1:0] flags;
      for (int p = 0; p < NP; p++) begin
         flags[p] = refOverflow[p];
      end
      return flags;
   endfunction

   // Reference model: what one rising edge does, in terms of the memory's rules.
   task automatic modelEdge();
      logic [DW-1:0] oldDout1;
      oldDout1 = expDout1;
      if (reset) begin
         expDout1   = '0;
         expDout2   = '0;
         expEnbPrev = 1'b0;
         for (int p = 0; p < NP; p++) begin
            refCount[p]    = 0;
            refOverflow[p] = 1'b0;
         end
      end else begin
         if (enb) expDout1 = refMem[readaddr];
         if (expEnbPrev) expDout2 = oldDout1;
         expEnbPrev = enb;
         for (int p = 0; p < NP; p++) begin
            if (nentries_we[p]) begin
               refCount[p] = int'(nentries_din[8*p +: 8]);
               if (refCount[p] > PD) refOverflow[p] = 1'b1;
            end
         end
      end
      if (ena && wea) refMem[writeaddr] = din;
   endtask

   task automatic checkAll();
      checkOutput("dout_lat1", 64'(dout1), 64'(expDout1));
      checkOutput("dout_lat2", 64'(dout2), 64'(expDout2));
      checkOutput("nentries_lat1", 64'(nentries_dout1), 64'(expectedCounts()));
      checkOutput("nentries_lat2", 64'(nentries_dout2), 64'(expectedCounts()));
      checkOutput("overflow_lat1", 64'(overflow1), 64'(expectedOverflow()));
      checkOutput("overflow_lat2", 64'(overflow2), 64'(expectedOverflow()));
   endtask

   // Drive one cycle of inputs, clock it, advance the model and compare.
   task automatic applyStimulus(input logic aEna, input logic aWea,
                                input logic [AW-1:0] aWaddr, input logic [DW-1:0] aDin,
                                input logic aEnb, input logic [AW-1:0] aRaddr,
                                input logic [NP-1:0] aNwe, input logic [8*NP-1:0] aNdin);
      ena          = aEna;
      wea          = aWea;
      writeaddr    = aWaddr;
      din          = aDin;
      enb          = aEnb;
      readaddr     = aRaddr;
      nentries_we  = aNwe;
      nentries_din = aNdin;
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
   endtask

   task automatic checkResetZero(input string tag);
      checkOutput({tag, "_dout1"}, 64'(dout1), 64'd0);
      checkOutput({tag, "_dout2"}, 64'(dout2), 64'd0);
      checkOutput({tag, "_nentries"}, 64'(nentries_dout1), 64'd0);
      checkOutput({tag, "_overflow"}, 64'(overflow1), 64'd0);
   endtask

   initial begin
      reset        = 1'b1;
      ena          = 1'b0;
      wea          = 1'b0;
      writeaddr    = '0;
      din          = '0;
      enb          = 1'b0;
      readaddr     = '0;
      nentries_we  = '0;
      nentries_din = '0;
      expDout1     = '0;
      expDout2     = '0;
      expEnbPrev   = 1'b0;
      for (int p = 0; p < NP; p++) begin
         refCount[p]    = 0;
         refOverflow[p] = 1'b0;
      end

      #2;
      checkResetZero("reset_start");
      @(negedge clk);
      reset = 1'b0;

      // Give every location a known value so reads never see uninitialised RAM.
      for (int i = 0; i < NWORDS; i++) begin
         applyStimulus(1'b1, 1'b1, AW'(i), DW'($urandom), 1'b0, '0, '0, '0);
      end

      applyStimulus(1'b1, 1'b1, 8'h05, 21'h1ABCD, 1'b0, '0, '0, '0);
      applyStimulus(1'b1, 1'b1, 8'h85, 21'h0F0F0, 1'b0, '0, '0, '0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 8'h05, '0, '0);
      checkOutput("read_0x05", 64'(dout1), 64'h1ABCD);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 8'h85, '0, '0);
      checkOutput("read_0x85", 64'(dout1), 64'h0F0F0);
      checkOutput("read_0x05_lat2", 64'(dout2), 64'h1ABCD);
      idleCycle();
      checkOutput("read_0x85_lat2", 64'(dout2), 64'h0F0F0);
      checkOutput("hold_lat1", 64'(dout1), 64'h0F0F0);

      applyStimulus(1'b1, 1'b1, 8'h10, 21'h00011, 1'b0, '0, '0, '0);
      applyStimulus(1'b1, 1'b1, 8'h10, 21'h00022, 1'b1, 8'h10, '0, '0);
      checkOutput("collision_old", 64'(dout1), 64'h00011);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 8'h10, '0, '0);
      checkOutput("collision_new", 64'(dout1), 64'h00022);

      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 2'b11, {8'd12, 8'd7});
      checkOutput("counts_both", 64'(nentries_dout1), 64'h0C07);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 2'b01, {8'd99, 8'd0});
      checkOutput("counts_page0_clear", 64'(nentries_dout1), 64'h0C00);

      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 2'b10, {8'd129, 8'd0});
      checkOutput("overflow_set", 64'(overflow1), 64'b10);
      checkOutput("overflow_count", 64'(nentries_dout1), 64'h8100);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 2'b10, {8'd5, 8'd0});
      checkOutput("overflow_sticky", 64'(overflow1), 64'b10);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 2'b01, {8'd0, 8'd128});
      checkOutput("exact_depth_ok", 64'(overflow1), 64'b10);
      checkOutput("exact_depth_count", 64'(nentries_dout1), 64'h0580);

      applyStimulus(1'b1, 1'b1, 8'h20, 21'h00033, 1'b0, '0, '0, '0);
      applyStimulus(1'b1, 1'b0, 8'h20, 21'h1FFFF, 1'b0, '0, '0, '0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 8'h20, '0, '0);
      checkOutput("no_wea_write", 64'(dout1), 64'h00033);

      // Mid-cycle reset with live counts, flags and read data.
      #2;
      reset = 1'b1;
      #1;
      checkResetZero("reset_mid");
      idleCycle();
      reset = 1'b0;
      idleCycle();
      checkResetZero("reset_after");

      for (int i = 0; i < 400; i++) begin
         logic [AW-1:0]   rWaddr;
         logic [AW-1:0]   rRaddr;
         logic [NP-1:0]   rNwe;
         logic [8*NP-1:0] rNdin;
         rWaddr = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 15))};
         rRaddr = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 15))};
         for (int p = 0; p < NP; p++) begin
            rNwe[p]          = ($urandom_range(0, 7) == 0);
            rNdin[8*p +: 8]  = 8'($urandom_range(0, 140));
         end
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rWaddr,
                       DW'($urandom), 1'($urandom_range(0, 1)), rRaddr, rNwe, rNdin);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
